// File: rtl/down_timer.sv
//------------------------------------------------------------------------------
// down_timer : loadable down-counting timer, one-shot or periodic auto-reload
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state  <= S_IDLE;
            r_out    <= c_ZERO;
            r_reload <= c_ZERO;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt  = S_RUN;
            w_out_nxt    = load_val;
            w_reload_nxt = load_val;
        end else if (r_state == S_RUN && en) begin
            if (r_out == c_ONE) begin
                w_tc_nxt = 1'b1;
                if (mode) begin
                    w_out_nxt = r_reload;
                end else begin
                    w_out_nxt   = c_ZERO;
                    w_state_nxt = S_IDLE;
                end
            end else begin
                // A count of zero wraps to all-ones, giving 2^WIDTH counts.
                w_out_nxt = r_out - c_ONE;
            end
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign busy = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_down_timer.sv
//------------------------------------------------------------------------------
// tb_down_timer : directed and random checks of down_timer against a model
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_down_timer;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_out    = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_tc     = 0;
    int edges_since_start = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .mode     (mode),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_out;
        exp_out = m_out[WIDTH-1:0];
        n_checks++;
        assert (out === exp_out) else begin
            n_fail++;
            $error("FAIL %s out: got %0d expected %0d", tag, out, exp_out);
        end
        n_checks++;
        assert (tc === m_tc) else begin
            n_fail++;
            $error("FAIL %s tc: got %b expected %b", tag, tc, m_tc);
        end
        n_checks++;
        assert (busy === m_run) else begin
            n_fail++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, m_run);
        end
    endtask

    // Apply one clock with the given inputs, advance the model, then check.
    task automatic cyc(input bit r, input bit s, input bit p, input bit e,
                       input bit m, input int lv, input string tag);
        @(negedge clk);
        res = r; start = s; stop = p; en = e; mode = m;
        load_val = lv[WIDTH-1:0];
        @(posedge clk);
        edges_since_start++;
        if (!r) begin
            m_run = 0; m_out = 0; m_tc = 0; m_reload = 0;
        end else if (p) begin
            m_run = 0; m_tc = 0;
        end else if (s) begin
            m_out = lv % MOD; m_reload = lv % MOD; m_run = 1; m_tc = 0;
            edges_since_start = 0;
        end else if (m_run && e) begin
            if (m_out == 1) begin
                m_tc = 1;
                if (m) m_out = m_reload;
                else begin m_out = 0; m_run = 0; end
            end else begin
                m_tc  = 0;
                m_out = (m_out + MOD - 1) % MOD;
            end
        end else begin
            m_tc = 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held with start asserted: nothing captured
        cyc(0, 1, 0, 1, 0, 5, "reset0");
        cyc(0, 1, 0, 1, 0, 5, "reset1");
        cyc(1, 0, 0, 1, 0, 0, "idle");

        // One-shot load 3
        cyc(1, 1, 0, 1, 0, 3, "os_start");
        repeat (5) cyc(1, 0, 0, 1, 0, 0, "os_run");

        // Periodic load 2 with en gaps
        cyc(1, 1, 0, 1, 1, 2, "per_start");
        cyc(1, 0, 0, 1, 1, 0, "per_en1");
        cyc(1, 0, 0, 0, 1, 0, "per_en0");
        cyc(1, 0, 0, 1, 1, 0, "per_en1b");
        cyc(1, 0, 0, 1, 1, 0, "per_en1c");
        repeat (4) cyc(1, 0, 0, 1, 1, 0, "per_run");

        // Wrap: load 0 takes 16 enabled edges to terminal count
        cyc(1, 1, 0, 1, 0, 0, "wrap_start");
        repeat (15) cyc(1, 0, 0, 1, 0, 0, "wrap_run");
        cyc(1, 0, 0, 1, 0, 0, "wrap_tc");
        n_checks++;
        assert (tc === 1'b1 && edges_since_start == 16 && out === '0) else begin
            n_fail++;
            $error("FAIL wrap_tc16 tc: got %b expected 1 at edge 16", tc);
        end

        // Start collides with terminal count
        cyc(1, 1, 0, 1, 0, 2, "col_s_load");
        cyc(1, 0, 0, 1, 0, 0, "col_s_at1");
        cyc(1, 1, 0, 1, 0, 7, "col_s_hit");
        n_checks++;
        assert (out === 4'd7 && tc === 1'b0) else begin
            n_fail++;
            $error("FAIL col_start out/tc: got %0d/%b expected 7/0", out, tc);
        end
        // Stop collides with terminal count
        cyc(1, 1, 0, 1, 0, 2, "col_p_load");
        cyc(1, 0, 0, 1, 0, 0, "col_p_at1");
        cyc(1, 0, 1, 1, 0, 0, "col_p_hit");
        n_checks++;
        assert (out === 4'd1 && tc === 1'b0 && busy === 1'b0) else begin
            n_fail++;
            $error("FAIL col_stop out/tc/busy: got %0d/%b/%b expected 1/0/0", out, tc, busy);
        end
        cyc(1, 0, 0, 1, 0, 0, "after_stop");
        // Start and stop together
        cyc(1, 1, 1, 1, 0, 9, "start_stop");

        // Reset mid-run at out = 4
        cyc(1, 1, 0, 1, 0, 6, "mr_load");
        cyc(1, 0, 0, 1, 0, 0, "mr_5");
        cyc(1, 0, 0, 1, 0, 0, "mr_4");
        cyc(0, 0, 0, 1, 0, 0, "mr_reset");
        cyc(1, 1, 0, 1, 0, 2, "mr_restart");
        repeat (3) cyc(1, 0, 0, 1, 0, 0, "mr_run");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1,
                int'($urandom_range(0, MOD - 1)),
                "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
